// File: rtl/cla_pipe_addsub_if.sv
// Operand/result handshake bundle for cla_pipe_addsub.
// The sub lane exists only when CLA_SUB_EN is defined.
interface cla_pipe_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef CLA_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             ovf;

`ifdef CLA_SUB_EN
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, carry_out, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, carry_out, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, carry_out, ovf
  );
`endif
endinterface

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-look-ahead adder, STAGES slices with valid/ready.
// Define CLA_SUB_EN for per-beat subtract (sub lane on the bus).
module cla_pipe_addsub #(
  parameter int WIDTH  = 16,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input logic           clk,
  input logic           rst_n,
  cla_pipe_addsub_if.slave bus
);
  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / BLOCK;

  if (STAGES < 1 || STAGES > WIDTH / BLOCK ||
      WIDTH % (STAGES * BLOCK) != 0) begin : g_bad
    $error("cla_pipe_addsub: bad WIDTH/BLOCK/STAGES");
  end

  // Returns {carry into slice MSB, slice carry out, slice sum}.
  function automatic logic [SW+1:0] cla(
    input logic [SW-1:0] x,
    input logic [SW-1:0] y,
    input logic          ci
  );
    logic [SW-1:0] g, p, c;
    logic [NG-1:0] gg, gp;
    logic [NG:0]   gc;
    logic          t;
    g = x & y;
    p = x ^ y;
    for (int j = 0; j < NG; j++) begin
      gp[j] = &p[j*BLOCK +: BLOCK];
      gg[j] = 1'b0;
      for (int i = 0; i < BLOCK; i++) begin
        t = g[j*BLOCK+i];
        for (int m = i + 1; m < BLOCK; m++)
          t = t & p[j*BLOCK+m];
        gg[j] = gg[j] | t;
      end
    end
    for (int j = 0; j <= NG; j++) begin
      t = ci;
      for (int m = 0; m < j; m++)
        t = t & gp[m];
      gc[j] = t;
      for (int i = 0; i < j; i++) begin
        t = gg[i];
        for (int m = i + 1; m < j; m++)
          t = t & gp[m];
        gc[j] = gc[j] | t;
      end
    end
    for (int j = 0; j < NG; j++) begin
      for (int i = 0; i < BLOCK; i++) begin
        t = gc[j];
        for (int m = 0; m < i; m++)
          t = t & p[j*BLOCK+m];
        c[j*BLOCK+i] = t;
        for (int l = 0; l < i; l++) begin
          t = g[j*BLOCK+l];
          for (int m = l + 1; m < i; m++)
            t = t & p[j*BLOCK+m];
          c[j*BLOCK+i] = c[j*BLOCK+i] | t;
        end
      end
    end
    return {c[SW-1], gc[NG], p ^ c};
  endfunction

  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [STAGES:0]  adv;

`ifdef CLA_SUB_EN
  assign b_eff = bus.sub ? ~bus.b : bus.b;
  assign c_eff = bus.cin ^ bus.sub;
`else
  assign b_eff = bus.b;
  assign c_eff = bus.cin;
`endif

  assign adv[STAGES] = bus.out_ready;
  assign bus.in_ready = adv[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int RW = WIDTH - k * SW;
    logic [RW-1:0]    xa, xb;
    logic [WIDTH-1:0] sp, sum_d, sum_q;
    logic             xc, xv;
    logic             v_q, c_q;
    logic [SW+1:0]    r;

    if (k == 0) begin : g_in
      assign xa = bus.a;
      assign xb = b_eff;
      assign xc = c_eff;
      assign xv = bus.in_valid;
      assign sp = '0;
    end else begin : g_mid
      assign xa = g_st[k-1].g_fwd.na_q;
      assign xb = g_st[k-1].g_fwd.nb_q;
      assign xc = g_st[k-1].c_q;
      assign xv = g_st[k-1].v_q;
      assign sp = g_st[k-1].sum_q;
    end

    assign adv[k] = ~v_q | adv[k+1];
    assign r = cla(xa[SW-1:0], xb[SW-1:0], xc);

    // Merge this slice's sum into the lower bits riding along.
    always_comb begin
      sum_d = sp;
      sum_d[k*SW +: SW] = r[SW-1:0];
    end

    // Stage register; data only moves with a real beat.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (adv[k]) begin
        v_q <= xv;
        if (xv) begin
          c_q   <= r[SW];
          sum_q <= sum_d;
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [RW-SW-1:0] na_q, nb_q;
      // Forward the operand bits later slices still need.
      always_ff @(posedge clk) begin
        if (adv[k] && xv) begin
          na_q <= xa[RW-1:SW];
          nb_q <= xb[RW-1:SW];
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic cm_q;
      // Carry into the MSB, kept for signed overflow.
      always_ff @(posedge clk) begin
        if (!rst_n)
          cm_q <= 1'b0;
        else if (adv[k] && xv)
          cm_q <= r[SW+1];
      end
    end
  end

  assign bus.out_valid = g_st[STAGES-1].v_q;
  assign bus.sum       = g_st[STAGES-1].sum_q;
  assign bus.carry_out = g_st[STAGES-1].c_q;
  assign bus.ovf       = g_st[STAGES-1].g_last.cm_q ^
                         g_st[STAGES-1].c_q;
endmodule
